// File: rtl/gray_stretch_src_pkg.sv
// Shared constants, state encodings and RGB565 expansion for the gray
// contrast-stretch pixel source.
package gray_stretch_src_pkg;

    localparam int unsigned COEF_R_DEF    = 77;
    localparam int unsigned COEF_G_DEF    = 150;
    localparam int unsigned COEF_B_DEF    = 29;
    localparam int unsigned MIN_RANGE_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    // 255 * 256: a gain of DIV_NUM/range maps a full range onto 0..255 in Q8.8
    localparam logic [15:0] DIV_NUM  = 16'd65280;
    localparam logic [15:0] GAIN_ONE = 16'd256;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicate the top bits so full-scale 565 maps to full-scale 888
    function automatic rgb888_t expand565(input logic [15:0] p);
        rgb888_t c;
        c.r = {p[15:11], p[15:13]};
        c.g = {p[10:5],  p[10:9]};
        c.b = {p[4:0],   p[4:2]};
        return c;
    endfunction

endpackage

// File: rtl/gray_div16.sv
// 16-by-8 sequential restoring divider, one quotient bit per cycle.
module gray_div16
    import gray_stretch_src_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient
);

    logic        busy_q, busy_d;
    logic [3:0]  cnt_q,  cnt_d;
    logic [7:0]  rem_q,  rem_d;
    logic [7:0]  dvs_q,  dvs_d;
    logic [15:0] quo_q,  quo_d;
    logic [8:0]  trial;
    logic [7:0]  diff;

    // quo_q starts as the dividend and is shifted out MSB-first while the
    // quotient bits shift in from the bottom.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        trial  = {rem_q, quo_q[15]};
        diff   = 8'(trial - {1'b0, dvs_q});
        if (busy_q) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = diff;
                quo_d = {quo_q[14:0], 1'b1};
            end else begin
                rem_d = trial[7:0];
                quo_d = {quo_q[14:0], 1'b0};
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                busy_d = 1'b0;
            end
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = 4'd0;
            rem_d  = 8'd0;
            dvs_d  = divisor;
            quo_d  = dividend;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dvs_q <= dvs_d;
        quo_q <= quo_d;
    end

    // done marks the final iteration; quotient is complete on the next cycle
    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == 4'd15);
    assign quotient = quo_q;

endmodule

// File: rtl/gray_stretch_src.sv
// RGB565 FIFO to gray LCD pixel source with per-frame min/max contrast
// stretch; the gain is recomputed by a sequential divider in vertical blank.
module gray_stretch_src
    import gray_stretch_src_pkg::*;
#(
    parameter int unsigned COEF_R    = COEF_R_DEF,
    parameter int unsigned COEF_G    = COEF_G_DEF,
    parameter int unsigned COEF_B    = COEF_B_DEF,
    parameter int unsigned MIN_RANGE = MIN_RANGE_DEF
)(
    input  logic        lcd_pclk,
    input  logic        rst,
    input  logic        data_req,
    input  logic [10:0] v_disp,
    input  logic        enh_en,
    input  logic [15:0] src_q,
    input  logic        src_empty,
    output logic        src_rd_en,
    output logic [23:0] pixel_data,
    output logic        frame_done,
    output logic        underflow,
    output logic [7:0]  cur_min,
    output logic [15:0] cur_gain
);

    localparam logic signed [9:0] MIN_RANGE_S = 10'(MIN_RANGE);

    function automatic logic [7:0] luma(input rgb888_t c);
        logic [15:0] sum;
        sum = 16'(COEF_R * c.r + COEF_G * c.g + COEF_B * c.b);
        return 8'(sum >> 8);
    endfunction

    function automatic logic [7:0] sat8(input logic [15:0] v);
        return (v[15:8] != 8'd0) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [7:0] stretch(input logic [7:0]  y,
                                           input logic [7:0]  mn,
                                           input logic [15:0] gain);
        logic signed [9:0] d_s;
        logic [23:0]       prod;
        d_s = $signed({2'b00, y}) - $signed({2'b00, mn});
        if (d_s < 0) begin
            d_s = '0;
        end
        prod = {16'd0, d_s[7:0]} * {8'd0, gain};
        return sat8(16'(prod >> 8));
    endfunction

    logic              req_q,        req_d;
    logic [10:0]       line_cnt_q,   line_cnt_d;
    logic [7:0]        acc_min_q,    acc_min_d;
    logic [7:0]        acc_max_q,    acc_max_d;
    logic [7:0]        lat_min_q,    lat_min_d;
    logic [7:0]        lat_max_q,    lat_max_d;
    logic [7:0]        div_min_q,    div_min_d;
    logic              ident_q,      ident_d;
    logic              frame_done_q, frame_done_d;
    logic              underflow_q,  underflow_d;
    logic [23:0]       pix_p1_q,     pix_p1_d;
    logic [1:0]        state_q,      state_d;
    logic [7:0]        cur_min_q,    cur_min_d;
    logic [15:0]       cur_gain_q,   cur_gain_d;

    rgb888_t           rgb_p0;
    logic [7:0]        y_p0;
    logic [7:0]        s_p0;
    logic              vld_p0;
    logic              line_end;
    logic              frame_end;
    logic signed [9:0] range_s;
    logic              range_ok;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [15:0]       div_quo;

    // Stage p0: combinational luma and stretch of the FIFO head
    always_comb begin
        rgb_p0    = expand565(src_q);
        y_p0      = luma(rgb_p0);
        s_p0      = stretch(y_p0, cur_min_q, cur_gain_q);
        vld_p0    = data_req & ~src_empty;
        line_end  = req_q & ~data_req;
        frame_end = line_end && ((line_cnt_q + 11'd1) == v_disp);
        range_s   = $signed({2'b00, lat_max_q}) - $signed({2'b00, lat_min_q});
        range_ok  = (range_s >= MIN_RANGE_S);
    end

    always_comb begin
        req_d        = data_req;
        line_cnt_d   = line_cnt_q;
        acc_min_d    = acc_min_q;
        acc_max_d    = acc_max_q;
        lat_min_d    = lat_min_q;
        lat_max_d    = lat_max_q;
        frame_done_d = frame_end;
        underflow_d  = underflow_q;
        pix_p1_d     = 24'd0;

        if (data_req) begin
            if (src_empty) begin
                underflow_d = 1'b1;
            end else if (enh_en) begin
                pix_p1_d = {s_p0, s_p0, s_p0};
            end else begin
                pix_p1_d = {y_p0, y_p0, y_p0};
            end
        end

        if (line_end) begin
            line_cnt_d = line_cnt_q + 11'd1;
        end

        // Frame end happens on a data_req low cycle, so no pixel is lost here
        if (frame_end) begin
            line_cnt_d = 11'd0;
            lat_min_d  = acc_min_q;
            lat_max_d  = acc_max_q;
            acc_min_d  = 8'hFF;
            acc_max_d  = 8'h00;
        end else if (vld_p0) begin
            if (y_p0 < acc_min_q) acc_min_d = y_p0;
            if (y_p0 > acc_max_q) acc_max_d = y_p0;
        end
    end

    // Gain update FSM; frame ends outside IDLE are dropped
    always_comb begin
        state_d    = state_q;
        div_min_d  = div_min_q;
        ident_d    = ident_q;
        cur_min_d  = cur_min_q;
        cur_gain_d = cur_gain_q;
        div_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_done_q) begin
                    div_min_d = lat_min_q;
                    if (range_ok) begin
                        div_start = 1'b1;
                        ident_d   = 1'b0;
                        state_d   = ST_DIV;
                    end else begin
                        ident_d   = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_LOAD;
                end else if (!div_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                if (ident_q) begin
                    cur_min_d  = 8'd0;
                    cur_gain_d = GAIN_ONE;
                end else begin
                    cur_min_d  = div_min_q;
                    cur_gain_d = div_quo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    gray_div16 u_div (
        .clk      (lcd_pclk),
        .rst      (rst),
        .start    (div_start),
        .dividend (DIV_NUM),
        .divisor  (range_s[7:0]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Stage p1: registered pixel and control state
    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            req_q        <= 1'b0;
            line_cnt_q   <= 11'd0;
            acc_min_q    <= 8'hFF;
            acc_max_q    <= 8'h00;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
            pix_p1_q     <= 24'd0;
            state_q      <= ST_IDLE;
            cur_min_q    <= 8'd0;
            cur_gain_q   <= GAIN_ONE;
        end else begin
            req_q        <= req_d;
            line_cnt_q   <= line_cnt_d;
            acc_min_q    <= acc_min_d;
            acc_max_q    <= acc_max_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
            pix_p1_q     <= pix_p1_d;
            state_q      <= state_d;
            cur_min_q    <= cur_min_d;
            cur_gain_q   <= cur_gain_d;
        end
    end

    always_ff @(posedge lcd_pclk) begin
        lat_min_q <= lat_min_d;
        lat_max_q <= lat_max_d;
        div_min_q <= div_min_d;
        ident_q   <= ident_d;
    end

    assign src_rd_en  = data_req & ~src_empty;
    assign pixel_data = pix_p1_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;
    assign cur_min    = cur_min_q;
    assign cur_gain   = cur_gain_q;

endmodule

// File: tb/tb_gray_stretch_src.sv
// Directed scoreboard bench for gray_stretch_src: frames of chosen luma
// values, gain recomputation, identity fallback, underflow and reset abort.
module tb_gray_stretch_src;
    import gray_stretch_src_pkg::*;

    logic        lcd_pclk = 1'b0;
    logic        rst;
    logic        data_req;
    logic [10:0] v_disp;
    logic        enh_en;
    logic [15:0] src_q;
    logic        src_empty;
    logic        src_rd_en;
    logic [23:0] pixel_data;
    logic        frame_done;
    logic        underflow;
    logic [7:0]  cur_min;
    logic [15:0] cur_gain;

    gray_stretch_src dut (
        .lcd_pclk   (lcd_pclk),
        .rst        (rst),
        .data_req   (data_req),
        .v_disp     (v_disp),
        .enh_en     (enh_en),
        .src_q      (src_q),
        .src_empty  (src_empty),
        .src_rd_en  (src_rd_en),
        .pixel_data (pixel_data),
        .frame_done (frame_done),
        .underflow  (underflow),
        .cur_min    (cur_min),
        .cur_gain   (cur_gain)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [15:0] line_px[$];
    logic [15:0] y2src[256];
    bit          y_ok[256];
    int          m_min, m_gain, s_min, s_max;
    int          fd_cnt, div_cnt, emp_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_luma(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]) * 8 + int'(p[15:11]) / 4;
        g = int'(p[10:5])  * 4 + int'(p[10:5])  / 16;
        b = int'(p[4:0])   * 8 + int'(p[4:0])   / 4;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic int ref_stretch(input int y);
        int d, s;
        d = (y < m_min) ? 0 : y - m_min;
        s = (d * m_gain) / 256;
        return (s > 255) ? 255 : s;
    endfunction

    task automatic cyc(input logic req, input logic emp, input logic [15:0] q);
        int          y;
        logic [23:0] e;
        data_req  = req;
        src_empty = emp;
        src_q     = q;
        e = 24'd0;
        if (!rst && req && !emp) begin
            y = ref_luma(q);
            if (y < s_min) s_min = y;
            if (y > s_max) s_max = y;
            if (enh_en) y = ref_stretch(y);
            e = {8'(y), 8'(y), 8'(y)};
        end
        exp_q.push_back(e);
        #1;
        if (req) chk("src_rd_en", 32'(src_rd_en), emp ? 32'd0 : 32'd1);
        @(posedge lcd_pclk);
        #1;
        chk("pixel_data", 32'(pixel_data), 32'(exp_q.pop_front()));
        if (frame_done) fd_cnt++;
        if (dut.state_q == ST_DIV) div_cnt++;
    endtask

    task automatic set_ys(input int a, input int b, input int c, input int d, input int e);
        line_px.delete();
        if (a >= 0) line_px.push_back(y2src[a]);
        if (b >= 0) line_px.push_back(y2src[b]);
        if (c >= 0) line_px.push_back(y2src[c]);
        if (d >= 0) line_px.push_back(y2src[d]);
        if (e >= 0) line_px.push_back(y2src[e]);
    endtask

    // Two active lines, three blank cycles after each; frame end on the 2nd
    task automatic frame();
        fd_cnt  = 0;
        div_cnt = 0;
        for (int l = 0; l < 2; l++) begin
            foreach (line_px[i]) cyc(1'b1, (l == 0 && i == emp_idx), line_px[i]);
            for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 16'h0000);
        end
    endtask

    task automatic vblank();
        for (int k = 0; k < 37; k++) cyc(1'b0, 1'b0, 16'h0000);
        if (s_max - s_min >= 16) begin
            m_min  = s_min;
            m_gain = 65280 / (s_max - s_min);
        end else begin
            m_min  = 0;
            m_gain = 256;
        end
        s_min = 255;
        s_max = 0;
        chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
        chk("cur_min", 32'(cur_min), 32'(m_min));
        chk("cur_gain", 32'(cur_gain), 32'(m_gain));
    endtask

    initial begin
        rst = 1'b1; data_req = 1'b0; src_empty = 1'b0; src_q = 16'h0000;
        enh_en = 1'b1; v_disp = 11'd2; emp_idx = -1;
        m_min = 0; m_gain = 256; s_min = 255; s_max = 0; fd_cnt = 0; div_cnt = 0;
        for (int p = 0; p < 65536; p++) begin
            int y;
            y = ref_luma(16'(p));
            if (!y_ok[y]) begin
                y_ok[y]  = 1'b1;
                y2src[y] = 16'(p);
            end
        end

        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 16'h0000);
        chk("rst_pixel_data", 32'(pixel_data), 32'd0);
        chk("rst_cur_gain", 32'(cur_gain), 32'd256);
        chk("rst_cur_min", 32'(cur_min), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_src_rd_en", 32'(src_rd_en), 32'd0);
        rst = 1'b0;

        // First frame: identity, white and black
        line_px = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
        frame();
        vblank();
        chk("f1_div_cycles", 32'(div_cnt), 32'd16);

        set_ys(50, 80, 125, 160, 200);
        frame();
        vblank();
        chk("f2_div_cycles", 32'(div_cnt), 32'd16);
        chk("f2_min50", 32'(cur_min), 32'd50);
        chk("f2_gain435", 32'(cur_gain), 32'd435);

        // Stretched: 127, 254, 0, 0, 255 (saturated)
        set_ys(125, 200, 50, 40, 230);
        frame();
        vblank();
        chk("f3_gain343", 32'(cur_gain), 32'd343);

        // Narrow range falls back to identity without dividing
        set_ys(100, 104, 107, 110, -1);
        frame();
        vblank();
        chk("f4_div_cycles", 32'(div_cnt), 32'd0);
        chk("f4_gain_identity", 32'(cur_gain), 32'd256);

        chk("underflow_before", 32'(underflow), 32'd0);
        emp_idx = 1;
        set_ys(30, 125, 240, -1, -1);
        frame();
        emp_idx = -1;
        vblank();
        chk("underflow_sticky", 32'(underflow), 32'd1);

        enh_en = 1'b0;
        set_ys(50, 80, 125, 160, 200);
        frame();
        vblank();
        chk("f6_div_cycles", 32'(div_cnt), 32'd16);
        chk("f6_gain435", 32'(cur_gain), 32'd435);

        // Plain gray: Y=125 shows as 7D7D7D
        set_ys(125, 50, 200, 90, -1);
        frame();
        vblank();
        chk("underflow_held", 32'(underflow), 32'd1);

        enh_en = 1'b1;
        set_ys(60, 100, 180, -1, -1);
        frame();
        for (int k = 0; k < 40 && div_cnt < 8; k++) cyc(1'b0, 1'b0, 16'h0000);
        chk("div_reached_8", 32'(div_cnt), 32'd8);
        chk("state_div_before_rst", 32'(dut.state_q), 32'(ST_DIV));
        rst = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000);
        chk("abort_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        chk("abort_cur_gain", 32'(cur_gain), 32'd256);
        chk("abort_cur_min", 32'(cur_min), 32'd0);
        chk("abort_line_cnt", 32'(dut.line_cnt_q), 32'd0);
        chk("abort_acc_min", 32'(dut.acc_min_q), 32'd255);
        chk("abort_acc_max", 32'(dut.acc_max_q), 32'd0);
        chk("abort_underflow", 32'(underflow), 32'd0);
        rst = 1'b0;
        m_min = 0; m_gain = 256; s_min = 255; s_max = 0;
        for (int k = 0; k < 30; k++) cyc(1'b0, 1'b0, 16'h0000);
        chk("abort_no_load", 32'(cur_gain), 32'd256);

        // First frame after reset is shown with identity parameters
        set_ys(125, 60, 220, -1, -1);
        frame();
        vblank();
        chk("f9_gain408", 32'(cur_gain), 32'd408);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_stretch_src.md
Name: gray_stretch_src

Overview:
Pixel source sitting directly upstream of the LCD timing driver. It answers the driver's data_req with pixel_data. Each pixel is popped from a show-ahead RGB565 frame FIFO, converted to 8-bit luma and linearly contrast-stretched, using min/max statistics gathered over the previous frame. At each frame end a sequential divider recomputes the stretch gain during vertical blanking.

Parameters:
COEF_R, 77, red luma weight (COEF_R+COEF_G+COEF_B = 256)
COEF_G, 150, green luma weight
COEF_B, 29, blue luma weight
MIN_RANGE, 16, if (max-min) < MIN_RANGE the identity stretch is used instead

Ports:
lcd_pclk  in  1  pixel clock, single clock domain
rst  in  1  synchronous, active-high reset
data_req  in  1  pixel request from the LCD driver, one cycle ahead of lcd_de
v_disp  in  11  active lines per frame
enh_en  in  1  1 = stretched output, 0 = plain gray output
src_q  in  16  show-ahead FIFO head, RGB565
src_empty  in  1  FIFO empty
src_rd_en  out  1  FIFO pop
pixel_data  out  24  gray pixel {Y,Y,Y} to the driver
frame_done  out  1  one-cycle pulse when the last active line ends
underflow  out  1  sticky; set when a request finds the FIFO empty
cur_min  out  8  stretch minimum currently applied
cur_gain  out  16  stretch gain currently applied, Q8.8

Behaviour:
- Reset values: pixel_data=0, src_rd_en=0, frame_done=0, underflow=0, cur_min=0, cur_gain=256 (identity). Reset also sets the line counter to 0, the accumulators to min=255/max=0, and the FSM to IDLE.
- src_rd_en = data_req & ~src_empty (combinational).
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Luma: Y=(COEF_R*R8+COEF_G*G8+COEF_B*B8)>>8, 16-bit sum, result 0..255.
- Stretch: d = Y<cur_min ? 0 : Y-cur_min; S = (d*cur_gain)>>8, saturated to 255.
- Latency is exactly 1 cycle. pixel_data is registered on the cycle data_req is high:
  - {S,S,S} if enh_en=1, else {Y,Y,Y};
  - if src_empty, pixel_data=0 and underflow is set.
- When data_req is low, pixel_data holds 0.
- Statistics: every valid pixel (data_req & ~src_empty) updates acc_min=min(acc_min,Y) and acc_max=max(acc_max,Y).
- Line counting: a falling edge of data_req increments line_cnt. When line_cnt reaches v_disp:
  - pulse frame_done;
  - clear line_cnt;
  - latch acc_min/acc_max into the divider inputs;
  - reset the accumulators to 255/0.
- FSM:
  - IDLE: on frame_done go to DIV.
  - DIV: restoring divide of 65280 by range=max-min, 1 quotient bit per cycle, 16 cycles, then go to LOAD.
  - LOAD: one cycle, updates cur_min/cur_gain, then returns to IDLE.
  - If range < MIN_RANGE, skip DIV: LOAD writes cur_min=0, cur_gain=256.
- cur_min/cur_gain change only in LOAD. LOAD falls inside vertical blanking (16 cycles << one blank line), so the gain never changes mid-frame.
- A frame_done arriving while not in IDLE is ignored, and the previous gain is kept.
- The first frame after reset is displayed with identity parameters.
- Reset asserted mid-frame or mid-divide aborts all activity and restores every reset value on the next edge.

Decomposition:
- Shared package: COEF_* defaults, the ST_IDLE/ST_DIV/ST_LOAD state encodings, DIV_NUM=16'd65280, GAIN_ONE=16'd256.
- Sub-module gray_div16: 16-by-8 sequential restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: busy, done, quotient[15:0].

Test Plan:
- Reset, then src_q=16'hFFFF with enh_en=1 and the first frame → pixel_data=24'hFFFFFF one cycle after each data_req; cur_gain=256; src_q=16'h0000 → 24'h000000.
- Frame of Y values 50..200 (min 50, max 200) → frame_done, 16 DIV cycles, then cur_min=50, cur_gain=435. Next frame: Y=125 → 8'd127, Y=200 → 8'd254, Y=50 → 0, Y=40 → 0, Y=230 → 255 (saturated).
- Frame with all Y in 100..110 (range 10 < MIN_RANGE) → cur_min=0, cur_gain=256; the next frame is passed through unchanged.
- Assert src_empty for one data_req cycle → pixel_data=0 that cycle, src_rd_en=0, underflow=1 and held until reset.
- enh_en=0 after a 50..200 frame → pixel_data={Y,Y,Y} (e.g. Y=125 gives 24'h7D7D7D), while statistics and the divider still run.
- Assert rst during the 8th DIV cycle → next cycle the FSM is IDLE, cur_gain=256, cur_min=0, and line_cnt and the accumulators are reset.
